// File: rtl/core_axil_write_bridge.sv
// Single-outstanding bridge from the core's request/done memory port to an AXI4-Lite master.
// A saturating per-transaction timer forces an error completion if a slave stops responding.
module core_axil_write_bridge #(
  parameter int AXI_AWIDTH     = 32,
  parameter int AXI_DWIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [AXI_AWIDTH-1:0]   mem_addr,
  input  logic [AXI_DWIDTH-1:0]   mem_wdata,
  input  logic [AXI_DWIDTH/8-1:0] mem_wstrb,
  output logic                    mem_ready,
  output logic                    mem_done,
  output logic                    mem_err,
  output logic [AXI_DWIDTH-1:0]   mem_rdata,
  output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam int TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_M1);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA} state_e;

  state_e                  state_q, state_d;
  logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_DWIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [AXI_DWIDTH-1:0]   rdata_q, rdata_d;

  logic completed;
  logic timeout_hit;
  logic aw_fin;
  logic w_fin;

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    timer_d     = timer_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    completed   = 1'b0;
    aw_fin      = 1'b0;
    w_fin       = 1'b0;
    mem_ready   = 1'b0;
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    AXI_BREADY  = 1'b0;
    AXI_ARVALID = 1'b0;
    AXI_RREADY  = 1'b0;

    timeout_hit = TO_EN && (state_q != IDLE) && (timer_q == TO_LAST);
    if ((state_q != IDLE) && (timer_q != {TW{1'b1}})) begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        // Hold off new requests during the completion pulse so done and accept never overlap.
        mem_ready = !done_q;
        if (mem_req && !done_q) begin
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          wstrb_d   = mem_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          timer_d   = '0;
          state_d   = mem_we ? WR : RADDR;
        end
      end
      WR: begin
        AXI_AWVALID = !aw_done_q;
        AXI_WVALID  = !w_done_q;
        AXI_BREADY  = 1'b1;
        aw_fin      = aw_done_q || AXI_AWREADY;
        w_fin       = w_done_q || AXI_WREADY;
        aw_done_d   = aw_fin;
        w_done_d    = w_fin;
        // A response arriving with the last address/data beat closes the write immediately.
        if (aw_fin && w_fin) begin
          if (AXI_BVALID) begin
            completed = 1'b1;
            done_d    = 1'b1;
            err_d     = (AXI_BRESP != 2'b00);
            state_d   = IDLE;
          end else begin
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        AXI_BREADY = 1'b1;
        if (AXI_BVALID) begin
          completed = 1'b1;
          done_d    = 1'b1;
          err_d     = (AXI_BRESP != 2'b00);
          state_d   = IDLE;
        end
      end
      RADDR: begin
        AXI_ARVALID = 1'b1;
        if (AXI_ARREADY) begin
          state_d = RDATA;
        end
      end
      RDATA: begin
        AXI_RREADY = 1'b1;
        if (AXI_RVALID) begin
          completed = 1'b1;
          done_d    = 1'b1;
          err_d     = (AXI_RRESP != 2'b00);
          rdata_d   = AXI_RDATA;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout_hit && !completed) begin
      done_d  = 1'b1;
      err_d   = 1'b1;
      rdata_d = '0;
      state_d = IDLE;
    end
  end

  assign mem_done   = done_q;
  assign mem_err    = err_q;
  assign mem_rdata  = rdata_q;
  assign AXI_AWADDR = addr_q;
  assign AXI_ARADDR = addr_q;
  assign AXI_WDATA  = wdata_q;
  assign AXI_WSTRB  = wstrb_q;

endmodule

// File: tb/tb_core_axil_write_bridge.sv
// Directed and randomized transactions against a latency-programmable AXI4-Lite slave,
// with expected completion timing and results computed from per-channel latencies.
module tb_core_axil_write_bridge;

  localparam int TO = 16;
  localparam int NEVER = 99;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_done;
  logic        mem_err;
  logic [31:0] mem_rdata;
  logic [31:0] AXI_AWADDR;
  logic        AXI_AWVALID;
  logic        AXI_AWREADY;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_WVALID;
  logic        AXI_WREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID;
  logic        AXI_BREADY;
  logic [31:0] AXI_ARADDR;
  logic        AXI_ARVALID;
  logic        AXI_ARREADY;
  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RVALID;
  logic        AXI_RREADY;

  core_axil_write_bridge #(
    .AXI_AWIDTH(32),
    .AXI_DWIDTH(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .AXI_ACLK(clk),
    .AXI_ARESETN(rst_n),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_done(mem_done),
    .mem_err(mem_err),
    .mem_rdata(mem_rdata),
    .AXI_AWADDR(AXI_AWADDR),
    .AXI_AWVALID(AXI_AWVALID),
    .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA),
    .AXI_WSTRB(AXI_WSTRB),
    .AXI_WVALID(AXI_WVALID),
    .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP),
    .AXI_BVALID(AXI_BVALID),
    .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR),
    .AXI_ARVALID(AXI_ARVALID),
    .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA),
    .AXI_RRESP(AXI_RRESP),
    .AXI_RVALID(AXI_RVALID),
    .AXI_RREADY(AXI_RREADY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave configuration (latencies in cycles) and per-transaction state.
  int          s_aw, s_w, s_b, s_ar, s_r;
  logic [1:0]  s_resp;
  logic [31:0] s_rdata;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit          aw_got, w_got, ar_got, b_done, r_done, b_fire, r_fire;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;

  task automatic slave_setup(input int aw, input int w, input int b, input int ar, input int r,
                             input logic [1:0] resp, input logic [31:0] rd);
    s_aw = aw; s_w = w; s_b = b; s_ar = ar; s_r = r; s_resp = resp; s_rdata = rd;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_done = 0; r_done = 0; b_fire = 0; r_fire = 0;
    AXI_AWREADY = 0; AXI_WREADY = 0; AXI_ARREADY = 0; AXI_BVALID = 0; AXI_RVALID = 0;
    AXI_BRESP = 0; AXI_RRESP = 0; AXI_RDATA = 0;
    cap_awaddr = 0; cap_wdata = 0; cap_wstrb = 0; cap_araddr = 0;
  endtask

  // Slave acts on the falling edge: DUT valids/readies are stable there for the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (b_fire) begin AXI_BVALID = 0; b_fire = 0; b_done = 1; end
      if (r_fire) begin AXI_RVALID = 0; r_fire = 0; r_done = 1; end
      if (ar_got && !r_done && !AXI_RVALID) begin
        if (r_cnt == s_r - 1) begin AXI_RVALID = 1; AXI_RDATA = s_rdata; AXI_RRESP = s_resp; end
        r_cnt++;
      end
      AXI_ARREADY = AXI_ARVALID && !ar_got && (ar_cnt == s_ar);
      if (AXI_ARVALID && !ar_got) ar_cnt++;
      if (AXI_ARREADY) begin ar_got = 1; cap_araddr = AXI_ARADDR; end
      AXI_AWREADY = AXI_AWVALID && !aw_got && (aw_cnt == s_aw);
      if (AXI_AWVALID && !aw_got) aw_cnt++;
      if (AXI_AWREADY) begin aw_got = 1; cap_awaddr = AXI_AWADDR; end
      AXI_WREADY = AXI_WVALID && !w_got && (w_cnt == s_w);
      if (AXI_WVALID && !w_got) w_cnt++;
      if (AXI_WREADY) begin w_got = 1; cap_wdata = AXI_WDATA; cap_wstrb = AXI_WSTRB; end
      if (aw_got && w_got && !b_done && !AXI_BVALID) begin
        if (b_cnt == s_b) begin AXI_BVALID = 1; AXI_BRESP = s_resp; end
        b_cnt++;
      end
      b_fire = AXI_BVALID && AXI_BREADY;
      r_fire = AXI_RVALID && AXI_RREADY;
    end
  end

  logic [31:0] exp_rdata = 32'h0;
  int          txn_id = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // One transaction from request to the cycle after completion.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int aw, input int w, input int b,
                        input int ar, input int r, input logic [1:0] resp,
                        input logic [31:0] rd, input bit junk);
    int raw, lat, n, awc, wc, arc;
    bit to, done, got_err;
    logic [31:0] got_rd;
    raw = we ? 1 + ((aw > w) ? aw : w) + b : 1 + ar + r;
    to  = (raw > TO);
    lat = to ? TO : raw;
    if (to) exp_rdata = 32'h0;
    else if (!we) exp_rdata = rd;

    @(posedge clk); #2;
    slave_setup(aw, w, b, ar, r, resp, rd);
    mem_req = 1; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    @(posedge clk); #2;
    if (junk) begin
      mem_we = ~we; mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
    end else begin
      mem_req = 0;
    end
    n = 0; awc = 0; wc = 0; arc = 0; done = 0; got_err = 0; got_rd = 0;
    while (n < 60 && !done) begin
      @(negedge clk);
      n++;
      if (AXI_AWVALID) awc++;
      if (AXI_WVALID) wc++;
      if (AXI_ARVALID) arc++;
      if (mem_done) begin
        done = 1; mem_req = 0; got_err = mem_err; got_rd = mem_rdata;
      end
    end
    mem_req = 0;
    $display("txn %0d: we=%0d addr=%h lat=%0d err=%0d rdata=%h (exp lat=%0d err=%0d)",
             txn_id, we, addr, n - 1, got_err, got_rd, lat, to ? 1 : (resp != 0));
    txn_id++;
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", 32'(n - 1), 32'(lat));
    chk("err", 32'(got_err), 32'(to ? 1'b1 : (resp != 2'b00)));
    chk("rdata", got_rd, exp_rdata);
    if (we) begin
      chk("awvalid_cycles", 32'(awc), 32'(imin(aw + 1, lat)));
      chk("wvalid_cycles", 32'(wc), 32'(imin(w + 1, lat)));
      if (!to) begin
        chk("awaddr", cap_awaddr, addr);
        chk("wdata", cap_wdata, wdata);
        chk("wstrb", 32'(cap_wstrb), 32'(strb));
      end
    end else begin
      chk("arvalid_cycles", 32'(arc), 32'(imin(ar + 1, lat)));
      if (!to) chk("araddr", cap_araddr, addr);
    end
    @(negedge clk);
    chk("done_pulse", 32'(mem_done), 32'd0);
    chk("ready_after", 32'(mem_ready), 32'd1);
    chk("idle_after", 32'(AXI_AWVALID | AXI_WVALID | AXI_ARVALID), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    slave_setup(0, 0, 0, 0, 1, 2'b00, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(mem_ready), 32'd1);
    chk("rst_done", 32'(mem_done), 32'd0);
    chk("rst_valids", 32'(AXI_AWVALID | AXI_WVALID | AXI_ARVALID), 32'd0);
    chk("rst_readies", 32'(AXI_BREADY | AXI_RREADY), 32'd0);
    chk("rst_awaddr", AXI_AWADDR, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    #2 rst_n = 1;

    do_txn(1, 32'hF000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    do_txn(1, 32'h0000_0040, 32'hCAFE_0001, 4'h3, 0, 3, 0, 0, 0, 2'b00, 0, 0);
    do_txn(1, 32'h0000_0044, 32'h0BAD_0BAD, 4'hC, 1, 1, 2, 0, 0, 2'b10, 0, 0);
    do_txn(0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'h1234_5678, 0);
    do_txn(0, 32'h0000_0200, 32'h0, 4'h0, 0, 0, 0, NEVER, 1, 2'b00, 32'h5555_AAAA, 0);
    do_txn(0, 32'h0000_0300, 32'h0, 4'h0, 0, 0, 0, 0, 15, 2'b01, 32'h7777_8888, 0);
    do_txn(0, 32'h0000_0304, 32'h0, 4'h0, 0, 0, 0, 0, 16, 2'b00, 32'h9999_0000, 0);
    do_txn(1, 32'h0000_0308, 32'h1111_2222, 4'h5, 2, 1, 12, 0, 0, 2'b00, 0, 1);
    do_txn(1, 32'h0000_030C, 32'h3333_4444, 4'hA, 2, 1, 13, 0, 0, 2'b00, 0, 0);

    // Reset pulse in the middle of a write whose slave never responds.
    @(posedge clk); #2;
    slave_setup(NEVER, NEVER, 0, 0, 1, 2'b00, 32'h0);
    mem_req = 1; mem_we = 1; mem_addr = 32'hABCD_0000; mem_wdata = 32'h1; mem_wstrb = 4'hF;
    @(posedge clk); #2;
    mem_req = 0;
    @(negedge clk); @(negedge clk);
    chk("mid_wr_awvalid", 32'(AXI_AWVALID & AXI_WVALID), 32'd1);
    #3 rst_n = 0;
    #1;
    chk("async_awvalid", 32'(AXI_AWVALID), 32'd0);
    chk("async_wvalid", 32'(AXI_WVALID), 32'd0);
    chk("async_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #3 rst_n = 1;
    exp_rdata = 32'h0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_done) cnt++;
    end
    $display("reset pulse: mem_done pulses after reset=%0d", cnt);
    chk("no_done_after_rst", 32'(cnt), 32'd0);
    do_txn(1, 32'hF000_0004, 32'h0000_00A5, 4'h1, 1, 0, 1, 0, 0, 2'b00, 0, 0);

    for (int k = 0; k < 40; k++) begin
      bit we;
      int aw, w, b, ar, r;
      we = 1'($urandom);
      aw = $urandom % 8; w = $urandom % 8; b = $urandom % 8;
      ar = $urandom % 8; r = 1 + ($urandom % 9);
      if ($urandom % 10 == 0) aw = NEVER;
      if ($urandom % 10 == 0) ar = NEVER;
      do_txn(we, $urandom, $urandom, 4'($urandom), aw, w, b, ar, r,
             2'($urandom), $urandom, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
